// File: rtl/core_reg_file_mp.sv
// core_reg_file_mp: multi-port register file with write forwarding and a hardware clear sequencer
module core_reg_file_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 30,
  parameter int RD_PORTS = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  output logic                      ready,
  input  logic [RD_PORTS*IDX_W-1:0] rd_index,
  output logic [RD_PORTS*WIDTH-1:0] rd_value,
  input  logic                      wr_a_enable,
  input  logic [IDX_W-1:0]          wr_a_index,
  input  logic [WIDTH-1:0]          wr_a_value,
  input  logic                      wr_b_enable,
  input  logic [IDX_W-1:0]          wr_b_index,
  input  logic [WIDTH-1:0]          wr_b_value
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] file [DEPTH];
  logic [RD_PORTS*WIDTH-1:0] rd_d;
  logic wa_ok, wb_ok;
  assign wa_ok = wr_a_enable && wr_a_index <= LAST;
  assign wb_ok = wr_b_enable && wr_b_index <= LAST;
  // clear sequencer: walk cnt over every entry, then hand over to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
      ready <= 1'b0;
    end else if (clear) begin
      state <= CLEAR;
      cnt <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      state <= cnt == LAST ? RUN : CLEAR;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      ready <= cnt == LAST;
    end
  end
  // array: zeroed by the sequencer in CLEAR, load port wins a same-index collision in RUN
  always_ff @(posedge clk) begin
    if (state == CLEAR) file[cnt] <= '0;
    else begin
      if (wa_ok) file[wr_a_index] <= wr_a_value;
      if (wb_ok) file[wr_b_index] <= wr_b_value;
    end
  end
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx = rd_index[p*IDX_W +: IDX_W];
    assign rd_d[p*WIDTH +: WIDTH] = (state != RUN || idx > LAST) ? '0 :
                                    (wb_ok && wr_b_index == idx) ? wr_b_value :
                                    (wa_ok && wr_a_index == idx) ? wr_a_value : file[idx];
  end
  // registered read ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_value <= '0;
    else rd_value <= rd_d;
  end
endmodule

// File: tb/tb_core_reg_file_mp.sv
// tb_core_reg_file_mp: directed self-checking bench for core_reg_file_mp
module tb_core_reg_file_mp;
  localparam int WIDTH = 32, DEPTH = 30, RD_PORTS = 2, IDX_W = 5;
  logic clk = 1'b0;
  logic rst_n, clear, ready;
  logic [RD_PORTS*IDX_W-1:0] rd_index;
  logic [RD_PORTS*WIDTH-1:0] rd_value;
  logic wr_a_enable, wr_b_enable;
  logic [IDX_W-1:0] wr_a_index, wr_b_index;
  logic [WIDTH-1:0] wr_a_value, wr_b_value;
  int errors = 0, checks = 0;

  core_reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready),
    .rd_index(rd_index), .rd_value(rd_value),
    .wr_a_enable(wr_a_enable), .wr_a_index(wr_a_index), .wr_a_value(wr_a_value),
    .wr_b_enable(wr_b_enable), .wr_b_index(wr_b_index), .wr_b_value(wr_b_value)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    clear = 1'b0;
    wr_a_enable = 1'b0;
    wr_b_enable = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b1; idle(); rd_index = '0;
    wr_a_index = '0; wr_a_value = '0; wr_b_index = '0; wr_b_value = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd_value); end
    step(); step();
    rst_n = 1'b1;
    wait_ready(n);
    checks++; if (n != 30) begin errors++; $display("FAIL reset_clear_len: got %0d want 30", n); end
    for (int i = 0; i < 15; i++) begin
      rd_index = {5'(i + 15), 5'(i)};
      step();
      checks++; if (rd_value !== '0) begin errors++; $display("FAIL reset_zero idx %0d: got %h want 0", i, rd_value); end
    end
  endtask

  task automatic test_write_read;
    wr_a_enable = 1'b1; wr_a_index = 5'd5; wr_a_value = 32'hDEADBEEF;
    rd_index = {5'd5, 5'd0};
    step();
    checks++; if (rd_value[31:0] !== 32'h0) begin errors++; $display("FAIL wr_rd_p0_old: got %h want 0", rd_value[31:0]); end
    checks++; if (rd_value[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_fwd_a: got %h want deadbeef", rd_value[63:32]); end
    idle();
    rd_index = {5'd5, 5'd5};
    step();
    checks++; if (rd_value !== {2{32'hDEADBEEF}}) begin errors++; $display("FAIL wr_rd_array: got %h want deadbeef x2", rd_value); end
  endtask

  task automatic test_forward;
    wr_a_enable = 1'b1; wr_a_index = 5'd3; wr_a_value = 32'h11;
    wr_b_enable = 1'b1; wr_b_index = 5'd3; wr_b_value = 32'h22;
    rd_index = {5'd3, 5'd3};
    step();
    checks++; if (rd_value !== {32'h22, 32'h22}) begin errors++; $display("FAIL fwd_b_wins: got %h want 22 x2", rd_value); end
    idle();
    step();
    checks++; if (rd_value !== {32'h22, 32'h22}) begin errors++; $display("FAIL fwd_array_b_wins: got %h want 22 x2", rd_value); end
  endtask

  task automatic test_split;
    wr_a_enable = 1'b1; wr_a_index = 5'd7; wr_a_value = 32'hAA;
    wr_b_enable = 1'b1; wr_b_index = 5'd8; wr_b_value = 32'hBB;
    rd_index = {5'd8, 5'd7};
    step();
    checks++; if (rd_value !== {32'hBB, 32'hAA}) begin errors++; $display("FAIL split_fwd: got %h want bb_aa", rd_value); end
    idle();
    rd_index = {5'd7, 5'd8};
    step();
    checks++; if (rd_value !== {32'hAA, 32'hBB}) begin errors++; $display("FAIL split_array: got %h want aa_bb", rd_value); end
  endtask

  task automatic test_clear;
    int m;
    for (int i = 0; i < 5; i++) begin
      wr_a_enable = 1'b1; wr_a_index = 5'(i); wr_a_value = 32'(i + 1);
      step();
    end
    idle();
    rd_index = {5'd0, 5'd4};
    step();
    checks++; if (rd_value !== {32'd1, 32'd5}) begin errors++; $display("FAIL fill_readback: got %h want 1_5", rd_value); end
    clear = 1'b1;
    wr_a_enable = 1'b1; wr_a_index = 5'd10; wr_a_value = 32'h77;
    step();
    clear = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready_drop: got %b want 0", ready); end
    wr_a_index = 5'd2; wr_a_value = 32'h99;
    wr_b_enable = 1'b1; wr_b_index = 5'd12; wr_b_value = 32'h55;
    rd_index = {5'd12, 5'd2};
    step();
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL clear_rd_zero: got %h want 0", rd_value); end
    wait_ready(m);
    checks++; if (m + 1 != 30) begin errors++; $display("FAIL clear_len: got %0d want 30", m + 1); end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      rd_index = {5'(29 - i), 5'(i)};
      step();
      checks++; if (rd_value !== '0) begin errors++; $display("FAIL clear_zero idx %0d: got %h want 0", i, rd_value); end
    end
  endtask

  task automatic test_clear_restart;
    int n;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (10) step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL restart_mid_ready: got %b want 0", ready); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_ready(n);
    checks++; if (n != 30) begin errors++; $display("FAIL restart_len: got %0d want 30", n); end
  endtask

  task automatic test_range;
    wr_a_enable = 1'b1; wr_a_index = 5'd31; wr_a_value = 32'h1234;
    wr_b_enable = 1'b1; wr_b_index = 5'd30; wr_b_value = 32'h5678;
    rd_index = {5'd30, 5'd31};
    step();
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL range_fwd: got %h want 0", rd_value); end
    idle();
    step();
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL range_array: got %h want 0", rd_value); end
    rd_index = {5'd0, 5'd1};
    step();
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL range_alias: got %h want 0", rd_value); end
  endtask

  task automatic test_async_reset;
    int n;
    wr_a_enable = 1'b1; wr_a_index = 5'd6; wr_a_value = 32'hCAFE;
    rd_index = {5'd6, 5'd6};
    step();
    idle();
    step();
    checks++; if (rd_value !== {32'hCAFE, 32'hCAFE} || ready !== 1'b1) begin errors++; $display("FAIL async_pre: got %h rdy %b want cafe x2 rdy 1", rd_value, ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", ready); end
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL async_rd: got %h want 0", rd_value); end
    #1 rst_n = 1'b1;
    wait_ready(n);
    checks++; if (n != 30) begin errors++; $display("FAIL async_clear_len: got %0d want 30", n); end
    step();
    checks++; if (rd_value !== '0) begin errors++; $display("FAIL async_rezero: got %h want 0", rd_value); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_split();
    test_clear();
    test_clear_restart();
    test_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_reg_file_mp.md
Name: core_reg_file_mp

Overview:
Parametrised multi-port successor to the core's single-read/single-write register file. It provides:
- RD_PORTS registered read ports and two write ports: ALU writeback and load/memory writeback.
- Same-cycle write-to-read forwarding.
- A hardware clear sequencer that zeroes the array after reset or on request, so the core never reads uninitialised registers.
It sits between the decode/issue stage (reads) and the writeback stage (writes) of the core pipeline.

Parameters:
WIDTH, 32, bits per register.
DEPTH, 30, physical registers, including banked copies.
RD_PORTS, 2, number of independent read ports.
IDX_W, $clog2(DEPTH), index width (derived, not overridable).

Ports:
Interface: one clock; reset is asynchronous and active-low.
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  single-cycle pulse; restart the clear sequence.
ready  out  1  high when the file is initialised and accepting writes.
rd_index  in  RD_PORTS*IDX_W  read indices; port p uses slice p.
rd_value  out  RD_PORTS*WIDTH  read data, registered; port p uses slice p.
wr_a_enable  in  1  ALU write enable.
wr_a_index  in  IDX_W  ALU write index.
wr_a_value  in  WIDTH  ALU write data.
wr_b_enable  in  1  load writeback enable.
wr_b_index  in  IDX_W  load write index.
wr_b_value  in  WIDTH  load write data.

Behaviour:
- FSM states: CLEAR, RUN. A clear counter cnt (IDX_W bits) runs alongside.
- Reset (rst_n low, asynchronous): state=CLEAR, cnt=0, ready=0, all rd_value=0. Array contents are not reset directly.
- CLEAR: each cycle write 0 to file[cnt] and increment cnt. When cnt==DEPTH-1, write it and go to RUN on the next edge. Clear takes exactly DEPTH cycles after rst_n rises.
  - ready=0 throughout CLEAR.
  - wr_a and wr_b are ignored.
  - rd_value registers load 0 every cycle.
- RUN: ready=1.
- Writes in RUN:
  - On a clk edge with wr_x_enable=1 and wr_x_index<DEPTH, file[wr_x_index] <= wr_x_value.
  - If both ports target the same index, wr_b (load) wins.
  - wr_x_index>=DEPTH: the write is discarded.
- Reads in RUN: rd_value[p] is registered with 1-cycle latency, sampled from rd_index[p] at the edge. Forwarding priority:
  1. wr_b enabled with index == rd_index[p]: return wr_b_value.
  2. Else wr_a enabled with index == rd_index[p]: return wr_a_value.
  3. Else return file[rd_index[p]].
  - rd_index[p]>=DEPTH returns 0.
- clear pulse in RUN: next edge goes to CLEAR, cnt=0, ready=0. Any write in that same cycle is still performed, then overwritten with 0 by the sequence.
- clear during CLEAR: cnt restarts at 0 and the sequence extends.
- Reset mid-clear or mid-run: immediate return to CLEAR with cnt=0. Already-written entries are re-zeroed.
- Read ports are independent: any number may read the same index, with no stalls.
- Write ports only write; they never stall and have no back-pressure.

Test Plan:
- Reset with DEPTH=30: release rst_n -> ready=0 for exactly 30 cycles, then 1. Every register read afterwards returns 0.
- After ready: write A idx5=0xDEADBEEF, next cycle read idx5 -> rd_value=0xDEADBEEF one cycle after the index is presented.
- Forwarding: same cycle wr_a idx3=0x11, wr_b idx3=0x22, read port0 idx3 and port1 idx3 -> both 0x22. A read one cycle later also gives 0x22.
- Split forwarding: wr_a idx7=0xAA, wr_b idx8=0xBB, port0 reads 7, port1 reads 8 -> 0xAA and 0xBB the same cycle.
- Mid-operation clear: fill idx0..4 with 1..5, pulse clear -> ready=0 for 30 cycles. Writes issued during clear are lost, and all reads return 0 once ready=1.
- Asynchronous reset and range checks:
  - Assert rst_n low between clk edges -> ready and rd_value go to 0 immediately, without waiting for an edge.
  - Write to idx 31 (out of range) -> ignored; a read of idx 31 returns 0.
